// File: rtl/mul_pipe.sv
// mul_pipe: STAGES-deep multiply pipeline for the EX path with valid/ready
// back-pressure from writeback, synchronous flush and MUL/MULH/MULHU/MULHSU select.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   valid_i / ready_o         issue handshake
//   op_i, wr_reg_i, a_i, b_i  operation, destination register, operands
//   flush_i                   kill all in-flight and same-cycle ops
//   stage_valid_o             bit k-1 = stage k holds a valid op
//   stage_wr_reg_o            slice k-1 = stage k destination register
//   wb_is_next_cycle_o        a result becomes valid next cycle
//   result_valid_o / result_ready_i   writeback handshake
//   wr_reg_o, result_o        destination register and selected product half
module mul_pipe #(
    parameter int REGISTER_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int STAGES         = 5
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [1:0]                         op_i,
    input  logic [REGISTER_WIDTH-1:0]          wr_reg_i,
    input  logic [DATA_WIDTH-1:0]              a_i,
    input  logic [DATA_WIDTH-1:0]              b_i,
    input  logic                               flush_i,
    output logic [STAGES-1:0]                  stage_valid_o,
    output logic [STAGES*REGISTER_WIDTH-1:0]   stage_wr_reg_o,
    output logic                               wb_is_next_cycle_o,
    output logic                               result_valid_o,
    input  logic                               result_ready_i,
    output logic [REGISTER_WIDTH-1:0]          wr_reg_o,
    output logic [DATA_WIDTH-1:0]              result_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic                      stall;
    logic                      advance;
    logic                      a_sext;
    logic                      b_sext;
    logic [PW-1:0]             a_ext;
    logic [PW-1:0]             b_ext;
    logic [PW-1:0]             prod;

    logic [STAGES-1:0]         valid_q;
    logic [1:0]                op_q   [STAGES];
    logic [REGISTER_WIDTH-1:0] reg_q  [STAGES];
    logic [PW-1:0]             prod_q [STAGES];

    // Operands are extended straight to the product width; the low 2*DATA_WIDTH
    // bits of that product equal those of the (DATA_WIDTH+1)-bit signed product.
    assign a_sext = op_i[0];
    assign b_sext = (op_i == 2'b01);
    assign a_ext  = {{DATA_WIDTH{a_sext & a_i[DATA_WIDTH-1]}}, a_i};
    assign b_ext  = {{DATA_WIDTH{b_sext & b_i[DATA_WIDTH-1]}}, b_i};
    assign prod   = a_ext * b_ext;

    assign stall   = valid_q[STAGES-1] & ~result_ready_i;
    assign advance = ~stall;
    assign ready_o = ~stall;

    assign wb_is_next_cycle_o = valid_q[STAGES-2] & ~stall & ~flush_i;

    assign result_valid_o = valid_q[STAGES-1];
    assign wr_reg_o       = reg_q[STAGES-1];
    assign result_o       = (op_q[STAGES-1] == 2'b00)
                          ? prod_q[STAGES-1][DATA_WIDTH-1:0]
                          : prod_q[STAGES-1][PW-1:DATA_WIDTH];

    assign stage_valid_o = valid_q;

    always_comb begin
        stage_wr_reg_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_wr_reg_o[k*REGISTER_WIDTH +: REGISTER_WIDTH] = reg_q[k];
        end
    end

    // Flush wins over stall: valids clear even when the output is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= {valid_q[STAGES-2:0], valid_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]   <= '0;
                reg_q[k]  <= '0;
                prod_q[k] <= '0;
            end
        end else if (advance) begin
            op_q[0]   <= op_i;
            reg_q[0]  <= wr_reg_i;
            prod_q[0] <= prod;
            for (int k = 1; k < STAGES; k++) begin
                op_q[k]   <= op_q[k-1];
                reg_q[k]  <= reg_q[k-1];
                prod_q[k] <= prod_q[k-1];
            end
        end
    end

endmodule
